// File: rtl/bit_order_deserializer.sv
// Serial-to-parallel word assembler with a per-word selectable bit order.
// It has a one-word output holding register so a new word can be collected while the previous one waits.
module bit_order_deserializer #(
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   msb_first,
   input  logic                   sin_data,
   input  logic                   sin_valid,
   output logic                   sin_ready,
   output logic [WIDTH-1:0]       word_out,
   output logic                   word_valid,
   input  logic                   word_ready,
   output logic [$clog2(WIDTH):0] bit_count
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic             order_q, order_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;

   logic             last_bit;
   logic             accept;
   logic             order_now;
   logic [WIDTH-1:0] shifted;

   assign last_bit  = (cnt_q == LAST);
   // Only the word-completing bit needs the holding register, so only it can stall.
   assign sin_ready = !(last_bit && valid_q && !word_ready);
   assign accept    = sin_valid && sin_ready;

   // The order is taken live on the first bit so that bit already lands correctly.
   assign order_now = (cnt_q == '0) ? msb_first : order_q;
   assign shifted   = order_now ? {shift_q[WIDTH-2:0], sin_data}
                                : {sin_data, shift_q[WIDTH-1:1]};

   always_comb begin
      cnt_d   = cnt_q;
      order_d = order_q;
      shift_d = shift_q;
      word_d  = word_q;
      valid_d = valid_q;
      if (valid_q && word_ready) begin
         valid_d = 1'b0;
      end
      if (accept) begin
         shift_d = shifted;
         if (cnt_q == '0) begin
            order_d = msb_first;
         end
         if (last_bit) begin
            cnt_d   = '0;
            word_d  = shifted;
            valid_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         order_q <= 1'b1;
         shift_q <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         order_q <= order_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign bit_count  = cnt_q;

endmodule

// File: tb/tb_bit_order_deserializer.sv
// Randomised bench for bit_order_deserializer against a bit-placement reference model.
// It also pins the model with literal words and checks the timing of the stall and reset cases.
module tb_bit_order_deserializer;

   localparam int W  = 32;
   localparam int CW = $clog2(W) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          msb_first;
   logic          sin_data;
   logic          sin_valid;
   logic          sin_ready;
   logic [W-1:0]  word_out;
   logic          word_valid;
   logic          word_ready;
   logic [CW-1:0] bit_count;

   bit_order_deserializer #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .msb_first  (msb_first),
      .sin_data   (sin_data),
      .sin_valid  (sin_valid),
      .sin_ready  (sin_ready),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .bit_count  (bit_count)
   );

   always #5 clk = ~clk;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;
   int unsigned dut_hs = 0;
   logic        chk_en = 1'b0;
   logic        rst_drv = 1'b1;
   logic        mf_drv = 1'b1;
   logic        mf_rand = 1'b0;
   logic        txq[$];

   // Reference model: bit position is derived directly from the bit index within the word.
   int unsigned m_cnt;
   logic        m_order;
   logic [W-1:0] m_build;
   logic [W-1:0] m_out;
   logic        m_valid;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push_word(input logic [W-1:0] w);
      for (int i = W - 1; i >= 0; i--) txq.push_back(w[i]);
   endtask

   task automatic tick(input int wrm, input int unsigned vpct);
      logic v, d, wr, exp_rdy;
      @(negedge clk);
      wr = (wrm == 2) ? ($urandom_range(0, 99) < 60) : (wrm == 1);
      v  = (txq.size() > 0) && ($urandom_range(0, 99) < vpct);
      d  = v ? txq[0] : logic'($urandom_range(0, 1));
      if (mf_rand) mf_drv = logic'($urandom_range(0, 1));
      sin_valid  = v;
      sin_data   = d;
      word_ready = wr;
      msb_first  = mf_drv;
      rst        = rst_drv;
      #1;
      exp_rdy = !((m_cnt == W - 1) && m_valid && !wr);
      if (chk_en) begin
         chk("sin_ready", 64'(sin_ready), 64'(exp_rdy));
         chk("bit_count", 64'(bit_count), 64'(m_cnt));
         chk("word_valid", 64'(word_valid), 64'(m_valid));
         chk("word_out", 64'(word_out), 64'(m_out));
         if (word_valid && word_ready) dut_hs++;
      end
      @(posedge clk);
      if (rst_drv) begin
         m_cnt = 0; m_order = 1'b1; m_build = '0; m_out = '0; m_valid = 1'b0;
      end else begin
         if (m_valid && wr) m_valid = 1'b0;
         if (v && exp_rdy) begin
            void'(txq.pop_front());
            if (m_cnt == 0) m_order = mf_drv;
            if (m_order) m_build[W - 1 - m_cnt] = d;
            else         m_build[m_cnt] = d;
            m_cnt++;
            if (m_cnt == W) begin
               m_out = m_build; m_valid = 1'b1; m_cnt = 0;
            end
         end
      end
      #1;
   endtask

   task automatic run(input int wrm, input int unsigned vpct, input int unsigned budget);
      int unsigned n = 0;
      while (txq.size() > 0 && n < budget) begin
         tick(wrm, vpct);
         n++;
      end
      if (txq.size() > 0) begin
         n_chk++; n_fail++;
         $display("FAIL run_timeout: %0d bits left, required 0", txq.size());
         txq.delete();
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      m_cnt = 0; m_order = 1'b1; m_build = '0; m_out = '0; m_valid = 1'b0;
      repeat (3) tick(1, 0);
      chk_en = 1'b1;
      tick(1, 0);
      chk("rst_bit_count", 64'(bit_count), 64'd0);
      chk("rst_word_valid", 64'(word_valid), 64'd0);
      chk("rst_word_out", 64'(word_out), 64'd0);
      rst_drv = 1'b0;
      tick(0, 0);
      chk("rst_sin_ready", 64'(sin_ready), 64'd1);

      // MSB-first, then LSB-first of the same stream.
      mf_drv = 1'b1;
      push_word(32'hA5A50F0F);
      run(1, 100, 100);
      chk("msb_word", 64'(word_out), 64'hA5A50F0F);
      chk("msb_valid_next", 64'(word_valid), 64'd1);
      tick(1, 100);
      chk("msb_valid_one_cycle", 64'(word_valid), 64'd0);
      mf_drv = 1'b0;
      push_word(32'hA5A50F0F);
      run(1, 100, 100);
      chk("lsb_word", 64'(word_out), 64'hF0F0A5A5);
      tick(1, 100);

      // Order change mid-word only takes effect on the next word.
      mf_drv = 1'b1;
      for (int i = W - 1; i >= W - 5; i--) txq.push_back(1'(32'h3C5A9617 >> i));
      run(1, 100, 50);
      mf_drv = 1'b0;
      for (int i = W - 6; i >= 0; i--) txq.push_back(1'(32'h3C5A9617 >> i));
      run(1, 100, 50);
      chk("toggle_word1", 64'(word_out), 64'h3C5A9617);
      push_word(32'h000000FF);
      run(1, 100, 50);
      chk("toggle_word2", 64'(word_out), 64'hFF000000);
      repeat (2) tick(1, 100);

      // Consumer stalled across two words.
      mf_drv = 1'b1;
      push_word(32'hDEADBEEF);
      push_word(32'hCAFEF00D);
      repeat (70) tick(0, 100);
      chk("stall_bit_count", 64'(bit_count), 64'd31);
      chk("stall_sin_ready", 64'(sin_ready), 64'd0);
      chk("stall_word_held", 64'(word_out), 64'hDEADBEEF);
      tick(1, 100);
      chk("stall_second_valid", 64'(word_valid), 64'd1);
      chk("stall_second_word", 64'(word_out), 64'hCAFEF00D);
      chk("stall_count_wrap", 64'(bit_count), 64'd0);
      repeat (2) tick(1, 100);

      // Reset mid-word discards partial bits.
      for (int i = 0; i < 10; i++) txq.push_back(logic'($urandom_range(0, 1)));
      run(1, 100, 20);
      rst_drv = 1'b1;
      tick(1, 0);
      rst_drv = 1'b0;
      chk("midrst_bit_count", 64'(bit_count), 64'd0);
      chk("midrst_word_valid", 64'(word_valid), 64'd0);
      push_word(32'h12345678);
      run(1, 100, 50);
      chk("midrst_word", 64'(word_out), 64'h12345678);
      repeat (2) tick(1, 100);

      // Random gaps, random order select, 1000 words.
      dut_hs  = 0;
      mf_rand = 1'b1;
      for (int k = 0; k < 1000; k++) push_word($urandom);
      run(2, 80, 95000);
      repeat (10) tick(1, 100);
      chk("random_word_count", 64'(dut_hs), 64'd1000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
